// File: rtl/id_regfile_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module   : id_regfile_scoreboard_pkg
// Brief    : Shared widths and types for the decode register file/scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
package id_regfile_scoreboard_pkg;

    localparam int XLEN  = 64;
    localparam int NREG  = 32;
    localparam int CNT_W = 2;

    typedef logic [4:0]       reg_idx_t;
    typedef logic [CNT_W-1:0] sb_cnt_t;
    typedef logic [XLEN-1:0]  xlen_t;

    localparam sb_cnt_t SB_MAX = {CNT_W{1'b1}};

endpackage
`default_nettype wire

// File: rtl/id_regfile_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module   : id_regfile_scoreboard_if
// Brief    : Decode read, issue and writeback signals of the register file.
// Revision : 1.0 - initial release
// ============================================================================
interface id_regfile_scoreboard_if;
    import id_regfile_scoreboard_pkg::*;

    reg_idx_t rs1_addr;
    reg_idx_t rs2_addr;
    logic     rs1_used;
    logic     rs2_used;
    xlen_t    rs1_data;
    xlen_t    rs2_data;
    logic     issue_valid;
    logic     issue_load;
    reg_idx_t issue_rd;
    logic     ex_flush;
    logic     wb_en;
    logic     wb_load;
    reg_idx_t wb_addr;
    xlen_t    wb_data;
    logic     ld_stall;

    modport master (
        output rs1_addr, rs2_addr, rs1_used, rs2_used,
        output issue_valid, issue_load, issue_rd, ex_flush,
        output wb_en, wb_load, wb_addr, wb_data,
        input  rs1_data, rs2_data, ld_stall
    );

    modport slave (
        input  rs1_addr, rs2_addr, rs1_used, rs2_used,
        input  issue_valid, issue_load, issue_rd, ex_flush,
        input  wb_en, wb_load, wb_addr, wb_data,
        output rs1_data, rs2_data, ld_stall
    );

endinterface
`default_nettype wire

// File: rtl/id_regfile_scoreboard_rf_array.sv
`default_nettype none
// ============================================================================
// Module   : id_regfile_scoreboard_rf_array
// Brief    : NREG x XLEN storage, 2 comb reads, 1 sync write, x0 reads zero.
//            REGFILE_WB_BYPASS_EN forwards the same-cycle write to the reads.
// Revision : 1.0 - initial release
// ============================================================================
module id_regfile_scoreboard_rf_array
    import id_regfile_scoreboard_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  reg_idx_t rs1_addr,
    input  reg_idx_t rs2_addr,
    output xlen_t    rs1_data,
    output xlen_t    rs2_data,
    input  logic     wr_en,
    input  reg_idx_t wr_addr,
    input  xlen_t    wr_data
);

    xlen_t r_regs [NREG];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
        end else if (wr_en && wr_addr != '0) begin
            r_regs[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        if (rs1_addr != '0) rs1_data = r_regs[rs1_addr];
        if (rs2_addr != '0) rs2_data = r_regs[rs2_addr];
`ifdef REGFILE_WB_BYPASS_EN
        if (wr_en && wr_addr == rs1_addr && rs1_addr != '0) rs1_data = wr_data;
        if (wr_en && wr_addr == rs2_addr && rs2_addr != '0) rs2_data = wr_data;
`endif
    end

endmodule
`default_nettype wire

// File: rtl/id_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : id_regfile_scoreboard
// Brief    : Decode register file plus per-register pending-load scoreboard
//            producing ld_stall. Option macro: REGFILE_WB_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module id_regfile_scoreboard
    import id_regfile_scoreboard_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    id_regfile_scoreboard_if.slave  rf
);

    sb_cnt_t  r_pend     [NREG];
    sb_cnt_t  w_pend_nxt [NREG];
    logic     r_last_ld_v;
    reg_idx_t r_last_ld_rd;

    logic     w_inc;
    logic     w_dec;
    logic     w_flush;
    logic     w_hz1;
    logic     w_hz2;
    logic     w_full;
    logic     w_stall;
    sb_cnt_t  w_eff1;
    sb_cnt_t  w_eff2;

    // Saturating at zero keeps a stray decrement from wrapping the counter.
    function automatic sb_cnt_t pend_next(sb_cnt_t cur, logic inc, logic dec, logic fl);
        logic [CNT_W:0] up;
        logic [CNT_W:0] dn;
        up = {1'b0, cur} + (CNT_W+1)'(inc);
        dn = (CNT_W+1)'(dec) + (CNT_W+1)'(fl);
        return (up > dn) ? sb_cnt_t'(up - dn) : '0;
    endfunction

    id_regfile_scoreboard_rf_array u_rf_array (
        .clk      (clk),
        .rst      (rst),
        .rs1_addr (rf.rs1_addr),
        .rs2_addr (rf.rs2_addr),
        .rs1_data (rf.rs1_data),
        .rs2_data (rf.rs2_data),
        .wr_en    (rf.wb_en),
        .wr_addr  (rf.wb_addr),
        .wr_data  (rf.wb_data)
    );

    always_comb begin
        w_dec   = rf.wb_en && rf.wb_load && rf.wb_addr != '0;
        w_flush = rf.ex_flush && r_last_ld_v;
        w_eff1  = r_pend[rf.rs1_addr];
        w_eff2  = r_pend[rf.rs2_addr];
`ifdef REGFILE_WB_BYPASS_EN
        if (w_dec && rf.wb_addr == rf.rs1_addr && w_eff1 != '0) w_eff1 = w_eff1 - sb_cnt_t'(1);
        if (w_dec && rf.wb_addr == rf.rs2_addr && w_eff2 != '0) w_eff2 = w_eff2 - sb_cnt_t'(1);
`endif
        w_hz1   = rf.rs1_used && rf.rs1_addr != '0 && w_eff1 != '0;
        w_hz2   = rf.rs2_used && rf.rs2_addr != '0 && w_eff2 != '0;
        w_full  = rf.issue_load && r_pend[rf.issue_rd] == SB_MAX;
        w_stall = rf.issue_valid && (w_hz1 || w_hz2 || w_full);
        w_inc   = rf.issue_valid && rf.issue_load && rf.issue_rd != '0 && !w_stall;
    end

    assign rf.ld_stall = w_stall;

    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            w_pend_nxt[i] = pend_next(r_pend[i],
                                      w_inc   && rf.issue_rd == reg_idx_t'(i),
                                      w_dec   && rf.wb_addr  == reg_idx_t'(i),
                                      w_flush && r_last_ld_rd == reg_idx_t'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) r_pend[i] <= '0;
            r_last_ld_v  <= 1'b0;
            r_last_ld_rd <= '0;
        end else begin
            r_pend      <= w_pend_nxt;
            r_last_ld_v <= w_inc;
            if (w_inc) r_last_ld_rd <= rf.issue_rd;
        end
    end

    // A load writeback must always match an outstanding load.
    a_no_pend_underflow: assert property (
        @(posedge clk) disable iff (rst) w_dec |-> r_pend[rf.wb_addr] != '0
    );

endmodule
`default_nettype wire

// File: tb/tb_id_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_regfile_scoreboard
// Brief    : Directed and random checks of id_regfile_scoreboard against a
//            behavioural register/pending-count model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_regfile_scoreboard;
    import id_regfile_scoreboard_pkg::*;

`ifdef REGFILE_WB_BYPASS_EN
    localparam bit c_byp = 1'b1;
`else
    localparam bit c_byp = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    id_regfile_scoreboard_if rf_if ();

    id_regfile_scoreboard dut (
        .clk (clk),
        .rst (rst),
        .rf  (rf_if)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [63:0] m_regs [32];
    int          m_pend [32];
    int          m_last;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] m_read(input int r);
        if (r == 0) return 64'd0;
        if (c_byp && rf_if.wb_en && int'(rf_if.wb_addr) == r) return rf_if.wb_data;
        return m_regs[r];
    endfunction

    function automatic bit m_busy(input int r);
        int c;
        c = m_pend[r];
        if (c_byp && rf_if.wb_en && rf_if.wb_load && int'(rf_if.wb_addr) == r && c > 0) c--;
        return (r != 0) && (c != 0);
    endfunction

    function automatic bit m_stall();
        return rf_if.issue_valid &&
               ((rf_if.rs1_used && m_busy(int'(rf_if.rs1_addr))) ||
                (rf_if.rs2_used && m_busy(int'(rf_if.rs2_addr))) ||
                (rf_if.issue_load && m_pend[rf_if.issue_rd] == 3));
    endfunction

    task automatic idle();
        rf_if.rs1_addr = '0;  rf_if.rs2_addr = '0;
        rf_if.rs1_used = 1'b0; rf_if.rs2_used = 1'b0;
        rf_if.issue_valid = 1'b0; rf_if.issue_load = 1'b0; rf_if.issue_rd = '0;
        rf_if.ex_flush = 1'b0;
        rf_if.wb_en = 1'b0; rf_if.wb_load = 1'b0; rf_if.wb_addr = '0; rf_if.wb_data = '0;
    endtask

    // Called at a negedge with inputs driven; checks, advances one clock, updates the model.
    task automatic tick();
        bit exp_stall;
        bit inc;
        int d [32];
        #1;
        exp_stall = m_stall();
        check("rs1_data", rf_if.rs1_data, m_read(int'(rf_if.rs1_addr)));
        check("rs2_data", rf_if.rs2_data, m_read(int'(rf_if.rs2_addr)));
        check("ld_stall", 64'(rf_if.ld_stall), 64'(exp_stall));
        @(posedge clk);
        if (rst) begin
            for (int r = 0; r < 32; r++) begin
                m_regs[r] = '0;
                m_pend[r] = 0;
            end
            m_last = 0;
        end else begin
            for (int r = 0; r < 32; r++) d[r] = 0;
            inc = rf_if.issue_valid && rf_if.issue_load && rf_if.issue_rd != 0 && !exp_stall;
            if (inc) d[rf_if.issue_rd]++;
            if (rf_if.wb_en && rf_if.wb_load && rf_if.wb_addr != 0) d[rf_if.wb_addr]--;
            if (rf_if.ex_flush && m_last != 0) d[m_last]--;
            for (int r = 0; r < 32; r++) m_pend[r] = (m_pend[r] + d[r] < 0) ? 0 : m_pend[r] + d[r];
            if (rf_if.wb_en && rf_if.wb_addr != 0) m_regs[rf_if.wb_addr] = rf_if.wb_data;
            m_last = inc ? int'(rf_if.issue_rd) : 0;
        end
        @(negedge clk);
    endtask

    task automatic issue_load(input int rd);
        idle();
        rf_if.issue_valid = 1'b1; rf_if.issue_load = 1'b1; rf_if.issue_rd = reg_idx_t'(rd);
        tick();
    endtask

    function automatic reg_idx_t rnd_reg();
        return ($urandom_range(0, 1) == 1) ? reg_idx_t'($urandom_range(0, 7)) : reg_idx_t'($urandom_range(0, 31));
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish before timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int bubbles;
        int cand [$];
        for (int r = 0; r < 32; r++) begin m_regs[r] = '0; m_pend[r] = 0; end
        m_last = 0;
        rst = 1'b1;
        idle();
        @(negedge clk);
        tick(); tick();
        rst = 1'b0;

        // Reset contents and dropped x0 write
        for (int r = 1; r < 32; r++) begin
            idle(); rf_if.rs1_addr = reg_idx_t'(r); rf_if.rs2_addr = reg_idx_t'(32 - r);
            tick();
        end
        idle(); rf_if.wb_en = 1'b1; rf_if.wb_addr = '0; rf_if.wb_data = 64'hDEAD;
        tick();
        idle(); #1;
        check("x0_after_write", rf_if.rs1_data, 64'd0);
        tick();

        // Same-cycle write/read of x5
        idle(); rf_if.wb_en = 1'b1; rf_if.wb_addr = 5'd5; rf_if.wb_data = 64'h1234; rf_if.rs1_addr = 5'd5;
        #1;
        check("x5_wb_cycle", rf_if.rs1_data, c_byp ? 64'h1234 : 64'd0);
        tick();
        idle(); rf_if.rs1_addr = 5'd5; #1;
        check("x5_next_cycle", rf_if.rs1_data, 64'h1234);
        tick();

        // Load-use penalty on x7
        issue_load(7);
        bubbles = 0;
        for (int k = 1; k <= 10; k++) begin
            idle();
            rf_if.issue_valid = 1'b1; rf_if.rs1_addr = 5'd7; rf_if.rs1_used = 1'b1;
            if (k == 3) begin
                rf_if.wb_en = 1'b1; rf_if.wb_load = 1'b1; rf_if.wb_addr = 5'd7; rf_if.wb_data = 64'hBEEF_0007;
            end
            #1;
            if (!rf_if.ld_stall) begin
                check("x7_load_value", rf_if.rs1_data, 64'hBEEF_0007);
                tick();
                break;
            end
            bubbles++;
            tick();
        end
        check("x7_bubbles", 64'(bubbles), c_byp ? 64'd2 : 64'd3);

        // Two loads in flight to x9
        issue_load(9);
        issue_load(9);
        for (int k = 0; k < 4; k++) begin
            idle();
            rf_if.issue_valid = 1'b1; rf_if.rs1_addr = 5'd9; rf_if.rs1_used = 1'b1;
            if (k == 0 || k == 2) begin
                rf_if.wb_en = 1'b1; rf_if.wb_load = 1'b1; rf_if.wb_addr = 5'd9; rf_if.wb_data = 64'(k + 90);
            end
            #1;
            check("x9_stall", 64'(rf_if.ld_stall), (k < 2 || (k == 2 && !c_byp)) ? 64'd1 : 64'd0);
            tick();
        end

        // Flushed load to x3 never stalls a consumer
        issue_load(3);
        idle(); rf_if.ex_flush = 1'b1; tick();
        idle(); rf_if.issue_valid = 1'b1; rf_if.rs1_addr = 5'd3; rf_if.rs1_used = 1'b1; #1;
        check("x3_flushed", 64'(rf_if.ld_stall), 64'd0);
        tick();

        // x0 load, unused busy rs2, counter saturation on x4
        issue_load(0);
        issue_load(4); issue_load(4); issue_load(4);
        idle(); rf_if.issue_valid = 1'b1; rf_if.issue_load = 1'b1; rf_if.issue_rd = 5'd4; #1;
        check("x4_full_stall", 64'(rf_if.ld_stall), 64'd1);
        tick();
        idle(); rf_if.issue_valid = 1'b1; rf_if.rs2_addr = 5'd4; rf_if.rs1_addr = 5'd1; #1;
        check("rs2_unused", 64'(rf_if.ld_stall), 64'd0);
        tick();
        idle(); rf_if.issue_valid = 1'b1; rf_if.rs2_addr = 5'd4; rf_if.rs2_used = 1'b1; #1;
        check("rs2_used_busy", 64'(rf_if.ld_stall), 64'd1);
        tick();
        check("x4_count", 64'(m_pend[4]), 64'd3);

        // Random traffic
        for (int n = 0; n < 4000; n++) begin
            idle();
            rst = ($urandom_range(0, 299) == 0);
            rf_if.rs1_addr    = rnd_reg();
            rf_if.rs2_addr    = rnd_reg();
            rf_if.rs1_used    = 1'($urandom_range(0, 1));
            rf_if.rs2_used    = 1'($urandom_range(0, 1));
            rf_if.issue_valid = ($urandom_range(0, 9) < 7);
            rf_if.issue_load  = ($urandom_range(0, 9) < 4);
            rf_if.issue_rd    = rnd_reg();
            rf_if.ex_flush    = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 1) == 1) begin
                rf_if.wb_en   = 1'b1;
                rf_if.wb_data = {32'($urandom), 32'($urandom)};
                cand.delete();
                for (int r = 1; r < 32; r++) if (m_pend[r] > 0) cand.push_back(r);
                if (cand.size() > 0 && $urandom_range(0, 9) < 6) begin
                    rf_if.wb_load = 1'b1;
                    rf_if.wb_addr = reg_idx_t'(cand[$urandom_range(0, cand.size() - 1)]);
                end else begin
                    rf_if.wb_addr = rnd_reg();
                end
            end
            tick();
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
